// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the register target and by the configuration master.
//   i2c_state_t    : target FSM states
//   AckLevel       : SDA level of an ACK bit
//   NackLevel      : SDA level of a NACK bit
//   DefaultDevAddr : 7-bit device address both ends agree on
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } i2c_state_t;

  localparam logic       AckLevel       = 1'b0;
  localparam logic       NackLevel      = 1'b1;
  localparam logic [6:0] DefaultDevAddr = 7'h1A;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Two-wire bus pins as seen by the register target.
//   scl_in : SCL pin level (asynchronous)
//   sda_in : SDA pin level (asynchronous, wired-AND line)
//   sda_oe : 1 = target pulls SDA low, 0 = released
// master modport drives the pins; slave modport is the target.
interface i2c_target_regs_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA and derives one-cycle bus events.
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   scl_in, sda_in         : raw pin levels
//   scl_rise, scl_fall     : one-cycle SCL edge pulses
//   start, stop            : one-cycle START / STOP pulses
//   sda                    : synchronised SDA level
module i2c_bus_sync (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;
  logic [1:0] settle_q;
  logic       armed;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
      settle_q   <= 2'd0;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // Events are masked until the pipeline holds real pin samples, so the reset
  // values cannot fabricate a START mid-transfer.
  assign armed    = (settle_q == 2'd3);
  assign scl_rise = armed & scl_sync_q & ~scl_hist_q;
  assign scl_fall = armed & ~scl_sync_q & scl_hist_q;
  assign start    = armed & scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop     = armed & scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
  assign sda      = sda_sync_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file (pointer-then-data writes,
// auto-incrementing reads).
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   bus                    : SCL/SDA pins and open-drain SDA enable
//   wr_strobe/addr/data    : one-cycle notification of an I2C register write
//   host_addr, host_rdata  : on-chip read port, one cycle latency
//   busy                   : addressed transaction in progress
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DefaultDevAddr,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned AW = $clog2(NUM_REGS)
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  i2c_target_regs_if.slave bus,
  output logic             wr_strobe,
  output logic [AW-1:0]    wr_addr,
  output logic [7:0]       wr_data,
  input  logic [AW-1:0]    host_addr,
  output logic [7:0]       host_rdata,
  output logic             busy
);

  logic scl_rise, scl_fall, start, stop, sda;

  i2c_bus_sync u_bus_sync (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .scl_in        (bus.scl_in),
    .sda_in        (bus.sda_in),
    .scl_rise      (scl_rise),
    .scl_fall      (scl_fall),
    .start         (start),
    .stop          (stop),
    .sda           (sda)
  );

  i2c_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          rw_q, rw_d;
  logic          got_ack_q, got_ack_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    host_rdata_q;
  logic [7:0]    rx_byte;
  logic [7:0]    rd_byte;

  assign rx_byte = {shift_q[6:0], sda};
  assign rd_byte = regs_q[ptr_q];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    rw_d        = rw_q;
    got_ack_d   = got_ack_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (stop) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d   = StAddr;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      got_ack_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_d = StAddrAck;
              rw_d    = rx_byte[0];
              busy_d  = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        // Ack states use sda_oe itself to tell the first fall (drive ACK)
        // from the second (end of the ACK clock).
        StAddrAck: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~AckLevel;
          end else begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              state_d  = StRdata;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = StPtr;
              sda_oe_d = 1'b0;
            end
          end
        end
        StPtr: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = rx_byte[AW-1:0];
            state_d = StPtrAck;
          end
        end
        StPtrAck: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~AckLevel;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = StWdata;
          end
        end
        StWdata: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr_q;
            wr_data_d   = rx_byte;
            state_d     = StWdataAck;
          end
        end
        StWdataAck: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~AckLevel;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            ptr_d     = ptr_q + 1'b1;
            state_d   = StWdata;
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d   = StRdataAck;
              got_ack_d = 1'b0;
            end
          end else if (scl_fall) begin
            // Rotate rather than shift so the whole byte stays in place.
            shift_d  = {shift_q[6:0], shift_q[7]};
            sda_oe_d = ~shift_q[6];
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            if (sda == NackLevel) begin
              state_d = StIgnore;
            end else begin
              ptr_d     = ptr_q + 1'b1;
              got_ack_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (got_ack_q) begin
              state_d   = StRdata;
              bit_cnt_d = 3'd0;
              got_ack_d = 1'b0;
              shift_d   = rd_byte;
              sda_oe_d  = ~rd_byte[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        StIgnore: sda_oe_d = 1'b0;
        StIdle:   sda_oe_d = 1'b0;
        default:  state_d  = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      rw_q        <= 1'b0;
      got_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      rw_q        <= rw_d;
      got_ack_q   <= got_ack_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register file; host_rdata sees the pre-write value in the write cycle.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      host_rdata_q <= 8'h00;
    end else begin
      if (wr_strobe_d) regs_q[wr_addr_d] <= wr_data_d;
      host_rdata_q <= regs_q[host_addr];
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = host_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C master, open-drain line model and a
// behavioural register/pointer model.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int unsigned NumRegs = 16;
  localparam int unsigned Q       = 8;  // clk cycles per quarter SCL period
  localparam logic [6:0]  DevAddr = 7'h1A;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl, m_sda, sda_force;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       busy;

  always #5 clk = ~clk;

  i2c_target_regs_if bus ();
  assign bus.scl_in = m_scl;
  // Wired-AND SDA; sda_force lets the bench overpower the target's pull-down.
  assign bus.sda_in = m_sda & (~bus.sda_oe | sda_force);

  i2c_target_regs #(
    .DEV_ADDR (DevAddr),
    .NUM_REGS (NumRegs)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .host_addr     (host_addr),
    .host_rdata    (host_rdata),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: append-only logs read by the main sequence.
  int          strobe_cnt  = 0;
  int          strobe_wide = 0;
  int          oe_cycles   = 0;
  logic        prev_strobe = 1'b0;
  logic [11:0] strobe_log[$];

  always @(posedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      strobe_log.push_back({wr_addr, wr_data});
      if (prev_strobe) strobe_wide++;
    end
    prev_strobe = wr_strobe;
    if (bus.sda_oe) oe_cycles++;
  end

  // Reference model
  logic [7:0] mregs [NumRegs];
  logic [7:0] tx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    b = bus.sda_in; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_addr = a;
    wait_clk(2);
    d = host_rdata;
  endtask

  // Full write transaction of tx_q starting at ptr; updates model and checks strobes.
  task automatic do_write(input logic [7:0] ptr);
    logic        ack;
    int          base, cnt0, idx, a;
    logic [11:0] obs;
    base = strobe_log.size();
    cnt0 = strobe_cnt;
    i2c_start();
    write_byte({DevAddr, 1'b0}, ack);
    check("wr_addr_ack", ack, AckLevel);
    check("busy_on", busy, 1'b1);
    write_byte(ptr, ack);
    check("ptr_ack", ack, AckLevel);
    foreach (tx_q[i]) begin
      write_byte(tx_q[i], ack);
      check("data_ack", ack, AckLevel);
    end
    i2c_stop();
    check("busy_off", busy, 1'b0);
    check("strobe_count", strobe_cnt - cnt0, tx_q.size());
    foreach (tx_q[i]) begin
      a = (int'(ptr) + i) % NumRegs;
      mregs[a] = tx_q[i];
      idx = base + i;
      obs = (idx < strobe_log.size()) ? strobe_log[idx] : 12'hxxx;
      check("strobe_addr_data", obs, {a[3:0], tx_q[i]});
    end
  endtask

  // Pointer write, repeated START, n-byte read ending in NACK.
  task automatic do_read(input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] d;
    int         a;
    i2c_start();
    write_byte({DevAddr, 1'b0}, ack);
    check("rd_waddr_ack", ack, AckLevel);
    write_byte(ptr, ack);
    check("rd_ptr_ack", ack, AckLevel);
    i2c_start();
    write_byte({DevAddr, 1'b1}, ack);
    check("rd_raddr_ack", ack, AckLevel);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      a = (int'(ptr) + i) % NumRegs;
      check("rd_data", d, mregs[a]);
    end
    check("oe_after_nack", bus.sda_oe, 1'b0);
    i2c_stop();
  endtask

  initial begin
    logic [7:0] d;
    logic       ack;
    int         cnt0, oe0, released;

    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; sda_force = 1'b0; host_addr = 4'd0;
    for (int i = 0; i < NumRegs; i++) mregs[i] = 8'h00;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    check("rst_sda_oe", bus.sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_host_rdata", host_rdata, 8'h00);

    // Basic write 0xA5 to reg 3
    tx_q = '{8'hA5};
    do_write(8'h03);
    host_read(4'd3, d);
    check("host_reg3", d, 8'hA5);

    // Pointer wrap 15 -> 0
    tx_q = '{8'h11, 8'h22};
    do_write(8'h0F);
    host_read(4'd15, d);
    check("host_reg15", d, 8'h11);
    host_read(4'd0, d);
    check("host_reg0", d, 8'h22);

    // Auto-increment read of reg2..reg4
    tx_q = '{8'h3C, 8'hC3, 8'h96};
    do_write(8'h02);
    do_read(8'h02, 3);

    // Foreign address is ignored entirely
    cnt0 = strobe_cnt;
    oe0  = oe_cycles;
    i2c_start();
    write_byte(8'hA0, ack);
    check("foreign_nack", ack, NackLevel);
    check("foreign_busy", busy, 1'b0);
    write_byte(8'h03, ack);
    write_byte(8'h55, ack);
    i2c_stop();
    check("foreign_no_oe", oe_cycles - oe0, 0);
    check("foreign_no_strobe", strobe_cnt - cnt0, 0);
    tx_q = '{8'h5A};
    do_write(8'h05);
    host_read(4'd5, d);
    check("after_foreign", d, 8'h5A);

    // Reset during the 5th data bit of a write to reg 6
    cnt0 = strobe_cnt;
    i2c_start();
    write_byte({DevAddr, 1'b0}, ack);
    write_byte(8'h06, ack);
    for (int i = 7; i >= 4; i--) send_bit(d[i]);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    rst_n = 1'b0; wait_clk(1);
    rst_n = 1'b1; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
    i2c_stop();
    for (int i = 0; i < NumRegs; i++) mregs[i] = 8'h00;
    check("abort_no_strobe", strobe_cnt - cnt0, 0);
    check("abort_busy", busy, 1'b0);
    for (int i = 0; i < NumRegs; i++) begin
      host_read(4'(i), d);
      check("abort_reg_clear", d, 8'h00);
    end
    tx_q = '{8'h77};
    do_write(8'h01);
    host_read(4'd1, d);
    check("post_reset_reg1", d, 8'h77);

    // STOP inside the pointer ACK slot
    i2c_start();
    write_byte({DevAddr, 1'b0}, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h04 >> i));
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    check("ptr_ack_drive", bus.sda_oe, 1'b1);
    sda_force = 1'b1;
    released  = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (!bus.sda_oe && released == 0) released = i;
    end
    check("stop_release_in_4", released != 0, 1'b1);
    check("stop_state_idle", dut.state_q, StIdle);
    check("stop_busy", busy, 1'b0);
    sda_force = 1'b0;
    wait_clk(Q);

    // Randomised writes and reads against the model
    for (int it = 0; it < 6; it++) begin
      int n;
      tx_q.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      do_write(8'($urandom));
      do_read(8'($urandom), $urandom_range(1, 4));
      host_addr = 4'($urandom);
      wait_clk(2);
      check("rand_host", host_rdata, mregs[host_addr]);
    end

    check("strobe_one_cycle", strobe_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
